// File: rtl/tetris_pkg.sv
// Shared board geometry, reader state encoding and the board bit-index helper
// used by both the host-side reader and the chip's piece placement.
package tetris_pkg;

    localparam int unsigned BOARD_W    = 8;
    localparam int unsigned BOARD_H    = 16;
    localparam int unsigned BEAT_W     = 8;
    localparam int unsigned BEATS      = BOARD_W * BOARD_H / BEAT_W;
    localparam int unsigned FRAME_W    = BOARD_W * BOARD_H;
    localparam int unsigned COUNT_W    = 8;
    localparam int unsigned X_W        = $clog2(BOARD_W);
    localparam int unsigned Y_W        = $clog2(BOARD_H);
    localparam int unsigned BIT_IDX_W  = $clog2(FRAME_W);
    localparam int unsigned BEAT_IDX_W = $clog2(BEATS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        DRAIN   = 2'd2,
        PUBLISH = 2'd3
    } gsr_state_t;

    // Column x, row y lives at bit x + BOARD_W*y of the flattened board.
    function automatic logic [BIT_IDX_W-1:0] bit_idx(input logic [X_W-1:0] x,
                                                     input logic [Y_W-1:0] y);
        return BIT_IDX_W'(x) + BIT_IDX_W'(BOARD_W) * BIT_IDX_W'(y);
    endfunction

endpackage

// File: rtl/game_state_reader_strobe_pacer.sv
// Issues STROBES single-cycle read strobes, each followed by GAP idle cycles.
// last_strobe is high during the final cycle of the burst (last strobe's gap).
module strobe_pacer #(
    parameter int unsigned GAP     = 0,
    parameter int unsigned STROBES = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic launch,
    output logic read_gs,
    output logic last_strobe
);

    localparam int unsigned GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam int unsigned CNT_W = $clog2(STROBES);
    localparam logic [GAP_W-1:0] GAP_END = GAP_W'(GAP);
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(STROBES - 1);
    localparam logic [CNT_W-1:0] CNT_PEN = CNT_W'(STROBES - 2);
    localparam bit NO_GAP = (GAP == 0);

    logic             active;
    logic [GAP_W-1:0] gap_cnt;
    logic [CNT_W-1:0] strb_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            active      <= 1'b0;
            read_gs     <= 1'b0;
            last_strobe <= 1'b0;
            gap_cnt     <= '0;
            strb_cnt    <= '0;
        end else if (launch) begin
            active      <= 1'b1;
            read_gs     <= 1'b1;
            last_strobe <= 1'b0;
            gap_cnt     <= '0;
            strb_cnt    <= '0;
        end else if (active) begin
            if (gap_cnt == GAP_END) begin
                if (strb_cnt == CNT_END) begin
                    active      <= 1'b0;
                    read_gs     <= 1'b0;
                    last_strobe <= 1'b0;
                end else begin
                    read_gs     <= 1'b1;
                    strb_cnt    <= strb_cnt + CNT_W'(1);
                    gap_cnt     <= '0;
                    last_strobe <= NO_GAP && (strb_cnt == CNT_PEN);
                end
            end else begin
                read_gs     <= 1'b0;
                gap_cnt     <= gap_cnt + GAP_W'(1);
                last_strobe <= ((gap_cnt + GAP_W'(1)) == GAP_END) && (strb_cnt == CNT_END);
            end
        end
    end

endmodule

// File: rtl/game_state_reader.sv
// Host-side board reader: strobes the chip once per row, reassembles the
// 128-bit board and publishes it atomically, with a combinational row readout.
module game_state_reader
    import tetris_pkg::*;
#(
    parameter int unsigned GAP = 0
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 continuous,
    input  logic [BEAT_W-1:0]    gs_data,
    output logic                 read_gs,
    output logic                 busy,
    output logic                 frame_valid,
    output logic [FRAME_W-1:0]   frame,
    output logic [COUNT_W-1:0]   frame_count,
    input  logic [Y_W-1:0]       row_sel,
    output logic [BEAT_W-1:0]    row_data
);

    gsr_state_t            state, state_nx;
    logic                  launch;
    logic                  last_strobe;
    logic                  strobe_d;
    logic [BEAT_IDX_W-1:0] cap_cnt;
    logic                  cap_full;
    logic                  cap_last;
    logic                  busy_nx;
    logic                  frame_valid_nx;
    logic [FRAME_W-1:0]    assembly;

    strobe_pacer #(
        .GAP     (GAP),
        .STROBES (BEATS)
    ) u_pacer (
        .clock       (clock),
        .reset_n     (reset_n),
        .launch      (launch),
        .read_gs     (read_gs),
        .last_strobe (last_strobe)
    );

    assign cap_last = strobe_d && (cap_cnt == BEAT_IDX_W'(BEATS - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // In PUBLISH a still-high read_gs means the next frame was already launched.
    always_comb begin
        state_nx       = state;
        launch         = 1'b0;
        busy_nx        = 1'b0;
        frame_valid_nx = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = READ;
                    launch   = 1'b1;
                end
            end
            READ:    if (last_strobe) state_nx = DRAIN;
            DRAIN: begin
                if (cap_full || cap_last) begin
                    state_nx = PUBLISH;
                    launch   = continuous;
                end
            end
            PUBLISH: state_nx = read_gs ? READ : IDLE;
            default: state_nx = IDLE;
        endcase
        busy_nx        = (state_nx != IDLE);
        frame_valid_nx = (state_nx == PUBLISH);
    end

    // Capture one row per delayed strobe; frame only changes on PUBLISH.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy        <= 1'b0;
            frame_valid <= 1'b0;
            strobe_d    <= 1'b0;
            cap_cnt     <= '0;
            cap_full    <= 1'b0;
            assembly    <= '0;
            frame       <= '0;
            frame_count <= '0;
        end else begin
            busy        <= busy_nx;
            frame_valid <= frame_valid_nx;
            strobe_d    <= read_gs;
            if (strobe_d) begin
                assembly[bit_idx('0, cap_cnt) +: BEAT_W] <= gs_data;
                cap_cnt <= cap_cnt + BEAT_IDX_W'(1);
            end
            if (launch)        cap_full <= 1'b0;
            else if (cap_last) cap_full <= 1'b1;
            if (state == PUBLISH) begin
                frame       <= assembly;
                frame_count <= frame_count + COUNT_W'(1);
            end
        end
    end

    assign row_data = frame[bit_idx('0, row_sel) +: BEAT_W];

endmodule

// File: tb/tb_game_state_reader.sv
// Bench for game_state_reader: two instances (GAP 0 and GAP 3) fed by a
// behavioural chip model that serves random per-frame board patterns.
module tb_game_state_reader;
    import tetris_pkg::*;

    localparam int NP   = 300;
    localparam int HIST = 5000;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic         reset_n;
    logic         start0, start3, cont0, cont3;
    logic [3:0]   rsel0, rsel3;
    logic [8:0]   io0, io3;
    logic         rg0, busy0, fv0, rg3, busy3, fv3;
    logic [127:0] frame0, frame3;
    logic [7:0]   fc0, fc3, rd0, rd3;

    game_state_reader #(.GAP(0)) dut0 (
        .clock(clock), .reset_n(reset_n), .start(start0), .continuous(cont0),
        .gs_data(io0[7:0]), .read_gs(rg0), .busy(busy0), .frame_valid(fv0),
        .frame(frame0), .frame_count(fc0), .row_sel(rsel0), .row_data(rd0));

    game_state_reader #(.GAP(3)) dut3 (
        .clock(clock), .reset_n(reset_n), .start(start3), .continuous(cont3),
        .gs_data(io3[7:0]), .read_gs(rg3), .busy(busy3), .frame_valid(fv3),
        .frame(frame3), .frame_count(fc3), .row_sel(rsel3), .row_data(rd3));

    // Chip model: strobe n returns row (n mod 16) of board pattern n/16, one cycle later.
    logic [127:0] pats [NP];

    function automatic logic [7:0] byte_of(input int idx);
        logic [127:0] p;
        p = pats[(idx / 16) % NP];
        p = p >> (8 * (idx % 16));
        return p[7:0];
    endfunction

    int cidx0, cidx3, sc0;
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cidx0 <= 0; io0 <= '0; cidx3 <= 0; io3 <= '0;
        end else begin
            if (rg0) begin io0 <= {1'b1, byte_of(cidx0)}; cidx0 <= cidx0 + 1; end
            if (rg3) begin io3 <= {1'b1, byte_of(cidx3)}; cidx3 <= cidx3 + 1; end
        end
    end
    always @(posedge clock) if (rg0 === 1'b1) sc0 <= sc0 + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    int           nf [2];
    logic [127:0] exp_prev [2];
    int           fv_at [NP];
    int           fv_n, frame_err, cnt_err;
    logic         rg_h [HIST];
    logic         busy_h [HIST];

    task automatic reset_model();
        for (int g = 0; g < 2; g++) begin nf[g] = 0; exp_prev[g] = '0; end
    endtask

    // Pulse start, then record one sample per cycle (negedge after edge E_j).
    task automatic observe(input int g, input int max_j, input int repulse_at, input int drop_at);
        bit pend;
        logic fv, rg, bz, s;
        logic [127:0] fr;
        logic [7:0] fc;
        fv_n = 0; frame_err = 0; cnt_err = 0; pend = 0;
        for (int k = 0; k < NP; k++) fv_at[k] = -1;
        if (g == 0) start0 = 1'b1; else start3 = 1'b1;
        for (int j = 0; j < max_j; j++) begin
            @(negedge clock);
            if (g == 0) begin fv = fv0; rg = rg0; bz = busy0; fr = frame0; fc = fc0; end
            else        begin fv = fv3; rg = rg3; bz = busy3; fr = frame3; fc = fc3; end
            rg_h[j] = rg; busy_h[j] = bz;
            if (pend) begin
                if (fr !== pats[nf[g]]) frame_err++;
                if (fc !== 8'(nf[g] + 1)) cnt_err++;
                exp_prev[g] = pats[nf[g]];
                nf[g]++;
                pend = 0;
            end else if (fr !== exp_prev[g]) begin
                frame_err++;
            end
            if (fv === 1'b1) begin
                if (fv_n < NP) fv_at[fv_n] = j;
                fv_n++;
                pend = 1;
                if (fv_n == drop_at) begin cont0 = 1'b0; cont3 = 1'b0; end
            end
            s = (j == repulse_at);
            if (g == 0) start0 = s; else start3 = s;
        end
    endtask

    function automatic int strobes_in(input int n);
        int c = 0;
        for (int j = 0; j < n; j++) if (rg_h[j] === 1'b1) c++;
        return c;
    endfunction

    // One non-continuous frame: strobe spacing, busy window, publish latency, result.
    task automatic check_single(input int g, input int G, input int repulse_at, input string tag);
        int fa, win, rg_err, bz_err;
        logic exp_rg;
        fa = 16 * (G + 1) + 1;
        win = fa + 20;
        rg_err = 0; bz_err = 0;
        observe(g, win, repulse_at, -1);
        for (int j = 0; j < win; j++) begin
            exp_rg = (j < 16 * (G + 1)) && (j % (G + 1) == 0);
            if (rg_h[j] !== exp_rg) rg_err++;
            if (busy_h[j] !== (j <= fa)) bz_err++;
        end
        check_int({tag, "_fv_pulses"}, fv_n, 1);
        check_int({tag, "_fv_latency"}, fv_at[0], fa);
        check_int({tag, "_strobe_count"}, strobes_in(win), 16);
        check_int({tag, "_strobe_pattern_errs"}, rg_err, 0);
        check_int({tag, "_busy_window_errs"}, bz_err, 0);
        check_int({tag, "_frame_hold_errs"}, frame_err, 0);
        check_int({tag, "_count_step_errs"}, cnt_err, 0);
        check({tag, "_frame"}, (g == 0) ? frame0 : frame3, pats[nf[g] - 1]);
        check({tag, "_frame_count"}, 128'((g == 0) ? fc0 : fc3), 128'(8'(nf[g])));
    endtask

    task automatic check_zero(input int g, input string tag);
        rsel0 = 4'($urandom_range(0, 15));
        rsel3 = 4'($urandom_range(0, 15));
        #1;
        check({tag, "_read_gs"},     128'((g == 0) ? rg0 : rg3), '0);
        check({tag, "_busy"},        128'((g == 0) ? busy0 : busy3), '0);
        check({tag, "_frame_valid"}, 128'((g == 0) ? fv0 : fv3), '0);
        check({tag, "_frame"},       (g == 0) ? frame0 : frame3, '0);
        check({tag, "_frame_count"}, 128'((g == 0) ? fc0 : fc3), '0);
        check({tag, "_row_data"},    128'((g == 0) ? rd0 : rd3), '0);
    endtask

    typedef struct {
        logic [3:0] sel;
        logic [7:0] exp;
    } row_vec_t;

    initial begin
        row_vec_t rv [18];
        logic [127:0] p;
        int b, w, sp_err;

        reset_n = 1'b0; start0 = 0; start3 = 0; cont0 = 0; cont3 = 0;
        rsel0 = '0; rsel3 = '0; sc0 = 0;
        reset_model();
        pats[0] = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        for (int k = 1; k < NP; k++) pats[k] = {$urandom, $urandom, $urandom, $urandom};

        repeat (3) @(negedge clock);
        check_zero(0, "rst0");
        check_zero(1, "rst3");
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        check_single(0, 0, -1, "gap0");
        check_single(1, 3, -1, "gap3");

        // Row readout of the GAP 3 frame.
        rv[0] = '{4'd0, 8'h10};
        rv[1] = '{4'd15, 8'h01};
        for (int i = 0; i < 16; i++) begin
            p = pats[0] >> (8 * i);
            rv[2 + i] = '{4'(i), p[7:0]};
        end
        for (int i = 0; i < 18; i++) begin
            rsel3 = rv[i].sel;
            #1;
            check($sformatf("row_data_sel%0d", rv[i].sel), 128'(rd3), 128'(rv[i].exp));
        end
        @(negedge clock);

        check_single(0, 0, 5, "restart");

        // Three back-to-back frames with continuous held until the 2nd publish.
        cont0 = 1'b1;
        observe(0, 100, -1, 2);
        check_int("cont_fv_pulses", fv_n, 3);
        check_int("cont_fv0", fv_at[0], 17);
        check_int("cont_fv1", fv_at[1], 34);
        check_int("cont_fv2", fv_at[2], 51);
        check_int("cont_strobes", strobes_in(100), 48);
        check_int("cont_frame_errs", frame_err, 0);
        check_int("cont_count_errs", cnt_err, 0);

        // Reset during a read aborts at once.
        start0 = 1'b1;
        @(negedge clock);
        start0 = 1'b0;
        b = sc0; w = 0;
        while ((sc0 - b) < 7 && w < 50) begin @(negedge clock); w++; end
        check_int("midrst_reach_strobe7", sc0 - b, 7);
        reset_n = 1'b0;
        check_zero(0, "midrst");
        @(negedge clock);
        reset_n = 1'b1;
        reset_model();
        @(negedge clock);
        check_single(0, 0, -1, "postrst");

        // 256 continuous frames from reset: frame_count wraps to 0.
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        reset_model();
        @(negedge clock);
        cont0 = 1'b1;
        observe(0, 256 * 17 + 30, -1, 255);
        sp_err = 0;
        for (int k = 1; k < 256; k++) if (fv_at[k] - fv_at[k - 1] != 17) sp_err++;
        check_int("wrap_fv_pulses", fv_n, 256);
        check_int("wrap_spacing_errs", sp_err, 0);
        check_int("wrap_strobes", strobes_in(256 * 17 + 30), 4096);
        check_int("wrap_frame_errs", frame_err, 0);
        check_int("wrap_count_errs", cnt_err, 0);
        check("wrap_frame_count", 128'(fc0), '0);
        check("wrap_frame", frame0, pats[255]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
